// File: rtl/uart_pkg.sv
// Shared constants, FSM state type and sizing helpers for the configurable UART receiver.
package uart_pkg;

  localparam int unsigned PARITY_NONE = 0;
  localparam int unsigned PARITY_ODD  = 1;
  localparam int unsigned PARITY_EVEN = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } rx_state_e;

  // Clock cycles per bit period.
  function automatic int unsigned bps_cnt(input int unsigned clk_hz, input int unsigned bps);
    return clk_hz / bps;
  endfunction

  // Bits needed to count 0..n-1 (at least one bit).
  function automatic int unsigned ctr_width(input int unsigned n);
    int unsigned w;
    w = 1;
    while ((32'd1 << w) < n) w++;
    return w;
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Input conditioning: 2-flop synchroniser, falling-edge detect and 3-sample majority voter.
module uart_rx_sync (
  input  logic sys_clk,
  input  logic sys_rst_n,
  input  logic uart_rxd,
  input  logic sample_en,
  output logic rxd_s,
  output logic fall_edge,
  output logic maj_bit
);

  logic       r_sync1;
  logic       r_sync2;
  logic       r_prev;
  logic [1:0] r_smp;

  // Synchroniser plus history flop; reset to idle-high so no edge appears out of reset.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_prev  <= 1'b1;
    end else begin
      r_sync1 <= uart_rxd;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
    end
  end

  // Hold the two earlier mid-bit samples; the third is the live synchronised level.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_smp <= 2'b11;
    end else if (sample_en) begin
      r_smp <= {r_smp[0], r_sync2};
    end
  end

  assign rxd_s     = r_sync2;
  assign fall_edge = r_prev & ~r_sync2;
  assign maj_bit   = (r_smp[1] & r_smp[0]) | (r_smp[1] & r_sync2) | (r_smp[0] & r_sync2);

endmodule

// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver with majority sampling, error flags and a valid/ready holding register.
module uart_rx_cfg
  import uart_pkg::*;
#(
  parameter int unsigned SYS_CLK_FRE = 50_000_000,
  parameter int unsigned BPS         = 9600,
  parameter int unsigned DATA_BITS   = 8,
  parameter int unsigned PARITY      = 0,
  parameter int unsigned STOP_BITS   = 1
) (
  input  logic                 sys_clk,
  input  logic                 sys_rst_n,
  input  logic                 uart_rxd,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun
);

  localparam int unsigned BPS_CNT = bps_cnt(SYS_CLK_FRE, BPS);
  localparam int unsigned MID     = BPS_CNT / 2;
  localparam int unsigned CW      = ctr_width(BPS_CNT);
  localparam int unsigned BW      = ctr_width(DATA_BITS);

  localparam logic [CW-1:0] CNT_LAST = CW'(BPS_CNT - 1);
  localparam logic [CW-1:0] CNT_SMP0 = CW'(MID - 1);
  localparam logic [CW-1:0] CNT_DEC  = CW'(MID + 1);
  localparam logic [BW-1:0] DATA_LAST = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);

  rx_state_e            r_state;
  logic [CW-1:0]        r_clk_cnt;
  logic [BW-1:0]        r_bit_cnt;
  logic [DATA_BITS-1:0] r_shift;
  logic                 r_perr;
  logic                 r_ferr;
  logic                 r_done;

  logic w_rxd_s_unused;
  logic w_fall;
  logic w_maj;
  logic w_sample_en;
  logic w_dec;
  logic w_bit_end;

  assign w_sample_en = (r_state != ST_IDLE) && (r_clk_cnt >= CNT_SMP0) && (r_clk_cnt <= CNT_DEC);
  assign w_dec       = (r_state != ST_IDLE) && (r_clk_cnt == CNT_DEC);
  assign w_bit_end   = (r_clk_cnt == CNT_LAST);

  uart_rx_sync u_sync (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .uart_rxd  (uart_rxd),
    .sample_en (w_sample_en),
    .rxd_s     (w_rxd_s_unused),
    .fall_edge (w_fall),
    .maj_bit   (w_maj)
  );

  // Frame FSM: bit timing, data shift, parity/stop checking and completion strobe.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_state   <= ST_IDLE;
      r_clk_cnt <= '0;
      r_bit_cnt <= '0;
      r_shift   <= '0;
      r_perr    <= 1'b0;
      r_ferr    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (r_state == ST_IDLE || w_bit_end) begin
        r_clk_cnt <= '0;
      end else begin
        r_clk_cnt <= r_clk_cnt + CW'(1);
      end

      case (r_state)
        ST_IDLE: begin
          if (w_fall) begin
            r_state <= ST_START;
            r_perr  <= 1'b0;
            r_ferr  <= 1'b0;
          end
        end
        ST_START: begin
          if (w_dec && w_maj) begin
            r_state <= ST_IDLE;
          end else if (w_bit_end) begin
            r_state   <= ST_DATA;
            r_bit_cnt <= '0;
          end
        end
        ST_DATA: begin
          if (w_dec) begin
            r_shift <= {w_maj, r_shift[DATA_BITS-1:1]};
          end
          if (w_bit_end) begin
            if (r_bit_cnt == DATA_LAST) begin
              r_bit_cnt <= '0;
              r_state   <= (PARITY != PARITY_NONE) ? ST_PARITY : ST_STOP;
            end else begin
              r_bit_cnt <= r_bit_cnt + BW'(1);
            end
          end
        end
        ST_PARITY: begin
          if (w_dec) begin
            r_perr <= (^r_shift) ^ w_maj ^ (PARITY == PARITY_ODD);
          end
          if (w_bit_end) begin
            r_state <= ST_STOP;
          end
        end
        ST_STOP: begin
          if (w_dec) begin
            if (!w_maj) begin
              r_ferr <= 1'b1;
            end
            // Finish at the last decision point so a back-to-back start edge is not missed.
            if (r_bit_cnt == STOP_LAST) begin
              r_done    <= 1'b1;
              r_bit_cnt <= '0;
              r_state   <= ST_IDLE;
            end
          end else if (w_bit_end) begin
            r_bit_cnt <= r_bit_cnt + BW'(1);
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // Holding register: load on completion if free or being drained, else flag overrun.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      overrun <= 1'b0;
      if (r_done) begin
        if (!rx_valid || rx_ready) begin
          rx_data    <= r_shift;
          parity_err <= r_perr;
          frame_err  <= r_ferr;
          rx_valid   <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
    end
  end

endmodule

// File: doc/uart_rx_cfg.md
Name: uart_rx_cfg

Overview:
Parametrised UART receiver, successor to the fixed 8N1 receiver.
- Configurable data width, parity mode and stop-bit count.
- 3-sample majority vote at mid-bit; false-start rejection.
- Parity, framing and overrun error reporting.
- Output is a valid/ready holding register, so downstream logic can stall without losing the frame in flight.

Parameters:
SYS_CLK_FRE, 50_000_000, system clock frequency in Hz
BPS, 9600, baud rate; BPS_CNT = SYS_CLK_FRE/BPS (integer divide), must be >= 8
DATA_BITS, 8, data bits per frame, legal range 5..9
PARITY, 0, 0 = none, 1 = odd, 2 = even
STOP_BITS, 1, number of stop bits, 1 or 2

Ports:
sys_clk  in  1  system clock, all logic on rising edge
sys_rst_n  in  1  asynchronous active-low reset
uart_rxd  in  1  serial input, asynchronous, idle high
rx_data  out  DATA_BITS  received word, LSB = first bit on the wire
rx_valid  out  1  rx_data and error flags valid
rx_ready  in  1  consumer accepts the word when rx_valid && rx_ready
parity_err  out  1  parity mismatch for the word held in rx_data (0 when PARITY=0)
frame_err  out  1  at least one stop bit sampled low for the held word
overrun  out  1  one-cycle pulse: a frame completed while the holding register was full; the new frame is dropped

Behaviour:
- Reset: all outputs 0. Synchroniser flops reset to 1 (idle line), so a spurious falling edge cannot occur after reset. FSM returns to IDLE, counters go to 0.
- Input path: 2-flop synchroniser, then a third flop for edge detection. Start edge = previous 1, current 0 on the synchronised signal.
- Timing:
  - clk_cnt runs 0..BPS_CNT-1 per bit period; width $clog2(BPS_CNT).
  - MID = BPS_CNT/2.
  - Samples are taken at clk_cnt = MID-1, MID, MID+1; the bit value is the majority of the three, decided at MID+1.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: on a start edge, go to START with clk_cnt = 0.
  - START: if the majority at MID is 1 (glitch), return to IDLE and produce no output. At clk_cnt = BPS_CNT-1, go to DATA with bit_cnt = 0.
  - DATA: shift the majority into the shift register LSB-first at each decision point. After bit DATA_BITS-1 ends, go to PARITY if PARITY != 0, otherwise STOP.
  - PARITY: compare the majority with the computed parity. Odd: XOR of data bits and parity bit must be 1. Even: that XOR must be 0. Mismatch sets the pending parity_err.
  - STOP:
    - Any stop-bit majority of 0 sets the pending frame_err.
    - Frame completes at the decision point (MID+1) of the last stop bit; the FSM then goes to IDLE immediately, without waiting for the bit end, to allow back-to-back frames.
- Completion (one cycle after the final decision):
  - If rx_valid = 0, or rx_valid && rx_ready in the same cycle: load rx_data, parity_err and frame_err; rx_valid = 1.
  - Otherwise (rx_valid && !rx_ready): keep the old word and flags; overrun = 1 for one cycle.
- Handshake:
  - rx_valid falls the cycle after rx_valid && rx_ready, unless a new word loads in that same cycle.
  - rx_data and the flags are stable while rx_valid && !rx_ready.
- A frame with errors is still delivered, with its flags set.
- A break (line held low) yields a word of 0 with frame_err = 1. No new start edge is detected until the line returns high.
- Latency: rx_valid rises MID+3 cycles after the last stop-bit period begins, plus 2 cycles of synchroniser delay from the pin.
- Reset mid-frame: the partial frame is discarded and no output is produced.

Decomposition:
- Package uart_pkg:
  - PARITY_NONE/ODD/EVEN constants
  - FSM state typedef
  - function bps_cnt(clk, bps)
  - function ctr_width
- Sub-module uart_rx_sync: synchroniser, edge detect, 3-sample majority voter. Inputs sys_clk, sys_rst_n, uart_rxd, sample_en; outputs rxd_s, fall_edge, maj_bit.

Test Plan:
Use SYS_CLK_FRE = 1_000_000, BPS = 100_000, so BPS_CNT = 10, MID = 5.
1. 8N1, send 0xA5, rx_ready = 1 → rx_data = 0xA5, rx_valid high for 1 cycle, parity_err = 0, frame_err = 0, overrun = 0.
2. DATA_BITS = 7, PARITY = 2 (even), send 0x35 with parity bit 1 → parity_err = 1, rx_data = 0x35. Resend with parity 0 → parity_err = 0.
3. STOP_BITS = 2, send 0x3C with the second stop bit driven low → rx_data = 0x3C, frame_err = 1. Next frame 0x00 with good stop bits → frame_err = 0.
4. Low glitch of 3 cycles on idle line → no rx_valid, FSM back in IDLE. One-cycle glitch at MID of a data bit of 0xFF → majority gives rx_data = 0xFF.
5. rx_ready = 0, send 0x11 then 0x22 back-to-back → rx_valid stays high with 0x11, overrun pulses once at the end of 0x22. Raise rx_ready → 0x11 consumed, rx_valid = 0.
6. Assert sys_rst_n = 0 during bit 4 of 0x5A → all outputs 0 immediately. After release, send 0x81 → only 0x81 is delivered.
